autocorr_capacity_core: RTL and testbench

AUTOCORR_CAPACITY_CORE -- requirements
Module: autocorr_capacity_core

---
 rtl/autocorr_capacity_core_pkg.sv | 17 +
 rtl/autocorr_capacity_core_log2_mitchell.sv | 24 ++
 rtl/autocorr_capacity_core.sv | 155 +++++++++++++++
 tb/tb_autocorr_capacity_core.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/autocorr_capacity_core_pkg.sv
// Shared widths and defaults for the autocorrelation sweep and capacity estimator.
package autocorr_capacity_core_pkg;

   localparam int unsigned DEF_SIZE = 256;
   localparam int unsigned DEF_CW   = 8;

   // Mitchell log2 result: 5-bit integer part, 8-bit fraction (Q5.8)
   localparam int unsigned Q_FRAC_W = 8;
   localparam int unsigned Q_INT_W  = 5;
   localparam int unsigned L2_W     = Q_INT_W + Q_FRAC_W;

   // Capacity operand and result widths
   localparam int unsigned CAP_W_W  = 8;
   localparam int unsigned CAP_SN_W = 16;
   localparam int unsigned CAP_C_W  = 24;

endpackage

// File: rtl/autocorr_capacity_core_log2_mitchell.sv
// Mitchell log2 approximation: leading-one index plus the 8 bits just below it.
module log2_mitchell
   import autocorr_capacity_core_pkg::*;
#(
   parameter int unsigned IW = CAP_SN_W + 1
) (
   input  logic [IW-1:0]   x,
   output logic [L2_W-1:0] l2_c
);

   logic [Q_INT_W-1:0] lead_c;
   logic [IW-1:0]      norm_c;

   // Find the leading one, normalise it to the MSB and take the next bits as fraction
   always_comb begin
      lead_c = '0;
      for (int i = 0; i < IW; i++) begin
         if (x[i]) lead_c = Q_INT_W'(i);
      end
      norm_c = x << (Q_INT_W'(IW - 1) - lead_c);
      l2_c   = {lead_c, Q_FRAC_W'(norm_c >> (IW - 1 - Q_FRAC_W))};
   end

endmodule

// File: rtl/autocorr_capacity_core.sv
// Circular autocorrelation sweep with peak tracking, plus a Shannon capacity estimate.
module autocorr_capacity_core
   import autocorr_capacity_core_pkg::*;
#(
   parameter int unsigned SIZE = DEF_SIZE,
   parameter int unsigned CW   = DEF_CW
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                enable,
   input  logic [SIZE-1:0]     signal_1,
   input  logic [SIZE-1:0]     signal_2,
   output logic [CW-1:0]       count,
   output logic [CW:0]         out,
   output logic                out_valid,
   output logic [CW-1:0]       best_pos,
   output logic [CW:0]         best_score,
   output logic                sweep_done,
   input  logic [CAP_W_W-1:0]  cap_w,
   input  logic [CAP_SN_W-1:0] cap_s,
   input  logic [CAP_SN_W-1:0] cap_n,
   output logic [CAP_C_W-1:0]  cap_c,
   output logic                cap_err
);

   logic [CW-1:0]       count_q,      count_d;
   logic [CW:0]         out_q,        out_d;
   logic                out_valid_q,  out_valid_d;
   logic [CW-1:0]       best_pos_q,   best_pos_d;
   logic [CW:0]         best_score_q, best_score_d;
   logic                sweep_done_q, sweep_done_d;
   logic [CW-1:0]       max_pos_q,    max_pos_d;
   logic [CW:0]         max_score_q,  max_score_d;
   logic [CAP_C_W-1:0]  cap_c_q,      cap_c_d;
   logic                cap_err_q,    cap_err_d;

   logic [2*SIZE-1:0]   dbl_c;
   logic [SIZE-1:0]     rot_c;
   logic [CW:0]         score_c;
   logic [CW-1:0]       base_pos_c;
   logic [CW:0]         base_score_c;

   logic [CAP_SN_W:0]   sn_c;
   logic [L2_W-1:0]     l_sn_c;
   logic [L2_W-1:0]     l_n_c;
   logic [L2_W-1:0]     diff_c;

   // Score for the current shift: rotate signal_2 by count, count matching bits
   always_comb begin
      dbl_c   = {signal_2, signal_2};
      rot_c   = SIZE'(dbl_c >> count_q);
      score_c = '0;
      for (int i = 0; i < SIZE; i++) begin
         score_c = score_c + (CW+1)'(signal_1[i] ~^ rot_c[i]);
      end
   end

   // Sweep control: advance shift, register score, track running peak, publish at wrap
   always_comb begin
      count_d      = count_q;
      out_d        = out_q;
      out_valid_d  = 1'b0;
      best_pos_d   = best_pos_q;
      best_score_d = best_score_q;
      sweep_done_d = 1'b0;
      max_pos_d    = max_pos_q;
      max_score_d  = max_score_q;
      base_pos_c   = max_pos_q;
      base_score_c = max_score_q;
      if (enable) begin
         count_d     = count_q + CW'(1);
         out_d       = score_c;
         out_valid_d = 1'b1;
         // a new sweep starts comparing against an empty peak
         if (count_q == '0) begin
            base_pos_c   = '0;
            base_score_c = '0;
         end
         if (score_c > base_score_c) begin
            max_pos_d   = count_q;
            max_score_d = score_c;
         end else begin
            max_pos_d   = base_pos_c;
            max_score_d = base_score_c;
         end
         if (count_q == CW'(SIZE - 1)) begin
            best_pos_d   = max_pos_d;
            best_score_d = max_score_d;
            sweep_done_d = 1'b1;
         end
      end
   end

   assign sn_c = (CAP_SN_W+1)'(cap_s) + (CAP_SN_W+1)'(cap_n);

   log2_mitchell #(.IW(CAP_SN_W + 1)) u_log_sn (
      .x    (sn_c),
      .l2_c (l_sn_c)
   );

   log2_mitchell #(.IW(CAP_SN_W)) u_log_n (
      .x    (cap_n),
      .l2_c (l_n_c)
   );

   // Capacity = W * max(0, L(S+N) - L(N)); zero noise is flagged as an error
   always_comb begin
      diff_c    = '0;
      cap_c_d   = '0;
      cap_err_d = 1'b0;
      if (l_sn_c > l_n_c) diff_c = l_sn_c - l_n_c;
      if (cap_n == '0) begin
         cap_err_d = 1'b1;
      end else begin
         cap_c_d = CAP_C_W'(cap_w) * CAP_C_W'(diff_c);
      end
   end

   // State registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_q      <= '0;
         out_q        <= '0;
         out_valid_q  <= 1'b0;
         best_pos_q   <= '0;
         best_score_q <= '0;
         sweep_done_q <= 1'b0;
         max_pos_q    <= '0;
         max_score_q  <= '0;
         cap_c_q      <= '0;
         cap_err_q    <= 1'b0;
      end else begin
         count_q      <= count_d;
         out_q        <= out_d;
         out_valid_q  <= out_valid_d;
         best_pos_q   <= best_pos_d;
         best_score_q <= best_score_d;
         sweep_done_q <= sweep_done_d;
         max_pos_q    <= max_pos_d;
         max_score_q  <= max_score_d;
         cap_c_q      <= cap_c_d;
         cap_err_q    <= cap_err_d;
      end
   end

   assign count      = count_q;
   assign out        = out_q;
   assign out_valid  = out_valid_q;
   assign best_pos   = best_pos_q;
   assign best_score = best_score_q;
   assign sweep_done = sweep_done_q;
   assign cap_c      = cap_c_q;
   assign cap_err    = cap_err_q;

endmodule

// File: tb/tb_autocorr_capacity_core.sv
// Self-checking bench for autocorr_capacity_core: capacity vectors, sweeps, pause and reset.
module tb_autocorr_capacity_core;

   localparam int SIZE = 256;
   localparam int CW   = 8;

   logic              clk = 1'b0;
   logic              reset;
   logic              enable;
   logic [SIZE-1:0]   signal_1;
   logic [SIZE-1:0]   signal_2;
   logic [CW-1:0]     count;
   logic [CW:0]       out;
   logic              out_valid;
   logic [CW-1:0]     best_pos;
   logic [CW:0]       best_score;
   logic              sweep_done;
   logic [7:0]        cap_w;
   logic [15:0]       cap_s;
   logic [15:0]       cap_n;
   logic [23:0]       cap_c;
   logic              cap_err;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [7:0]  w;
      logic [15:0] s;
      logic [15:0] n;
      logic [23:0] c;
      logic        err;
   } cap_vec_t;

   cap_vec_t tbl[8];

   autocorr_capacity_core dut (
      .clk        (clk),
      .reset      (reset),
      .enable     (enable),
      .signal_1   (signal_1),
      .signal_2   (signal_2),
      .count      (count),
      .out        (out),
      .out_valid  (out_valid),
      .best_pos   (best_pos),
      .best_score (best_score),
      .sweep_done (sweep_done),
      .cap_w      (cap_w),
      .cap_s      (cap_s),
      .cap_n      (cap_n),
      .cap_c      (cap_c),
      .cap_err    (cap_err)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input longint act, input longint exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Mitchell log2 in Q.8 from plain arithmetic
   function automatic int mlog(input int x);
      int ip;
      if (x == 0) return 0;
      ip = 0;
      while ((x >> (ip + 1)) != 0) ip++;
      return ip * 256 + ((x - (1 << ip)) * 256) / (1 << ip);
   endfunction

   function automatic int cap_model(input int w, input int s, input int n);
      int d;
      if (n == 0) return 0;
      d = mlog(s + n) - mlog(n);
      if (d < 0) d = 0;
      return w * d;
   endfunction

   // Circular match count for shift k
   function automatic int score_model(input logic [SIZE-1:0] a, input logic [SIZE-1:0] b, input int k);
      int s;
      s = 0;
      for (int i = 0; i < SIZE; i++) begin
         if (a[i] == b[(i + k) % SIZE]) s++;
      end
      return s;
   endfunction

   function automatic logic [SIZE-1:0] rand_vec();
      logic [SIZE-1:0] v;
      for (int j = 0; j < SIZE / 32; j++) v[j*32 +: 32] = $urandom;
      return v;
   endfunction

   task automatic check_zero_outputs(input string tag);
      chk({tag, "_count"}, count, 0);
      chk({tag, "_out"}, out, 0);
      chk({tag, "_out_valid"}, out_valid, 0);
      chk({tag, "_best_pos"}, best_pos, 0);
      chk({tag, "_best_score"}, best_score, 0);
      chk({tag, "_sweep_done"}, sweep_done, 0);
      chk({tag, "_cap_c"}, cap_c, 0);
      chk({tag, "_cap_err"}, cap_err, 0);
   endtask

   // One full sweep from k=0, optionally pausing enable for gap_len cycles before shift gap_at
   task automatic run_sweep(input string tag, input logic [SIZE-1:0] a, input logic [SIZE-1:0] b,
                            input int gap_at, input int gap_len);
      int sc[SIZE];
      int bp, bs;
      bp = 0;
      bs = 0;
      for (int k = 0; k < SIZE; k++) begin
         sc[k] = score_model(a, b, k);
         if (sc[k] > bs) begin
            bs = sc[k];
            bp = k;
         end
      end
      signal_1 = a;
      signal_2 = b;
      for (int k = 0; k < SIZE; k++) begin
         if (k == gap_at) begin
            enable = 1'b0;
            for (int g = 0; g < gap_len; g++) begin
               step();
               chk({tag, "_gap_valid"}, out_valid, 0);
               chk({tag, "_gap_count"}, count, k);
               chk({tag, "_gap_out_hold"}, out, sc[k-1]);
               chk({tag, "_gap_done"}, sweep_done, 0);
            end
         end
         enable = 1'b1;
         step();
         chk({tag, "_out"}, out, sc[k]);
         chk({tag, "_valid"}, out_valid, 1);
         chk({tag, "_count"}, count, (k + 1) % SIZE);
         chk({tag, "_done"}, sweep_done, (k == SIZE - 1) ? 1 : 0);
      end
      enable = 1'b0;
      chk({tag, "_best_pos"}, best_pos, bp);
      chk({tag, "_best_score"}, best_score, bs);
      step();
      chk({tag, "_done_pulse_end"}, sweep_done, 0);
      chk({tag, "_idle_valid"}, out_valid, 0);
   endtask

   initial begin
      logic [SIZE-1:0] a;
      logic [SIZE-1:0] b;
      int cycles;
      int w, s, n, e;

      tbl[0] = '{w: 8'd1,   s: 16'd31,    n: 16'd1,     c: 24'h000500, err: 1'b0};
      tbl[1] = '{w: 8'd2,   s: 16'd3,     n: 16'd1,     c: 24'h000400, err: 1'b0};
      tbl[2] = '{w: 8'd5,   s: 16'd100,   n: 16'd0,     c: 24'h000000, err: 1'b1};
      tbl[3] = '{w: 8'd0,   s: 16'd100,   n: 16'd100,   c: 24'h000000, err: 1'b0};
      tbl[4] = '{w: 8'd255, s: 16'd65535, n: 16'd65535, c: 24'h00FF00, err: 1'b0};
      tbl[5] = '{w: 8'd3,   s: 16'd0,     n: 16'd7,     c: 24'h000000, err: 1'b0};
      tbl[6] = '{w: 8'd10,  s: 16'd2,     n: 16'd2,     c: 24'h000A00, err: 1'b0};
      tbl[7] = '{w: 8'd1,   s: 16'd1,     n: 16'd3,     c: 24'h000080, err: 1'b0};

      reset    = 1'b1;
      enable   = 1'b0;
      signal_1 = '0;
      signal_2 = '0;
      cap_w    = '0;
      cap_s    = '0;
      cap_n    = '0;
      repeat (3) step();
      check_zero_outputs("reset");
      @(negedge clk);
      reset = 1'b0;

      // Capacity table
      foreach (tbl[i]) begin
         cap_w = tbl[i].w;
         cap_s = tbl[i].s;
         cap_n = tbl[i].n;
         step();
         chk($sformatf("cap_tbl%0d_c", i), cap_c, tbl[i].c);
         chk($sformatf("cap_tbl%0d_err", i), cap_err, tbl[i].err);
      end

      // Randomised capacity against the arithmetic model
      for (int j = 0; j < 40; j++) begin
         w = $urandom_range(0, 255);
         s = $urandom_range(0, 65535);
         case (j % 4)
            0:       n = (j % 8 == 0) ? 0 : $urandom_range(1, 20);
            1:       n = $urandom_range(1, 300);
            default: n = $urandom_range(0, 65535);
         endcase
         cap_w = 8'(w);
         cap_s = 16'(s);
         cap_n = 16'(n);
         step();
         e = cap_model(w, s, n);
         chk($sformatf("cap_rand%0d_c", j), cap_c, e);
         chk($sformatf("cap_rand%0d_err", j), cap_err, (n == 0) ? 1 : 0);
      end
      chk("count_idle", count, 0);

      // All-ones sweep: every shift matches fully, first position wins
      a = '1;
      run_sweep("ones", a, a, -1, 0);
      chk("ones_best_pos_abs", best_pos, 0);
      chk("ones_best_score_abs", best_score, 256);

      // Half-ones pattern rotated by 64
      a = '0;
      for (int i = 0; i < 128; i++) a[i] = 1'b1;
      b = '0;
      for (int i = 0; i < SIZE; i++) b[(i + 64) % SIZE] = a[i];
      chk("rot_score_k192", score_model(a, b, 192), 0);
      run_sweep("rot64", a, b, -1, 0);
      chk("rot64_best_pos_abs", best_pos, 64);
      chk("rot64_best_score_abs", best_score, 256);

      // Random sweep with a 10-cycle enable pause mid-sweep
      a = rand_vec();
      b = rand_vec();
      run_sweep("gap", a, b, 100, 10);

      // Random sweep uninterrupted
      a = rand_vec();
      b = a;
      for (int i = 0; i < 40; i++) b[$urandom_range(0, SIZE - 1)] ^= 1'b1;
      run_sweep("rand", a, b, -1, 0);

      // Reset at k=100 abandons the sweep
      cap_w = 8'd1;
      cap_s = 16'd31;
      cap_n = 16'd1;
      signal_1 = rand_vec();
      signal_2 = rand_vec();
      enable = 1'b1;
      repeat (100) step();
      chk("pre_reset_count", count, 100);
      chk("pre_reset_cap_c", cap_c, 24'h000500);
      #2;
      reset = 1'b1;
      #1;
      check_zero_outputs("midreset");
      @(negedge clk);
      reset  = 1'b0;
      enable = 1'b1;
      cycles = 0;
      while (cycles < 300) begin
         step();
         cycles++;
         if (sweep_done) break;
      end
      chk("post_reset_sweep_len", cycles, 256);
      chk("post_reset_count", count, 0);
      enable = 1'b0;
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
